// File: rtl/periph_bus_pkg.sv
// ============================================================================
// Module : periph_bus_pkg
// Brief  : Shared widths, command/device codes and arbiter state encoding for
//          the peripheral command bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package periph_bus_pkg;

  localparam int DEV_W  = 5;
  localparam int CMD_W  = 6;
  localparam int DATA_W = 32;

  localparam logic [5:0] CMD_NOP   = 6'd0;
  localparam logic [5:0] CMD_WRITE = 6'd1;

  localparam logic [4:0] DEV_LED  = 5'd0;
  localparam logic [4:0] DEV_IDLE = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/periph_bus_arbiter_rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotate-priority selector; first set request bit
//          searching upward from last_owner+1, wrapping modulo NUM_REQ.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_owner,
  output logic [NUM_REQ-1:0] o_winner,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  always_comb begin : p_pick
    logic [IDX_W-1:0] w_cand;
    logic             w_found;
    o_winner = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(i_last_owner) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_idx            = w_cand;
        o_winner[w_cand] = 1'b1;
      end
    end
    o_any = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
// ============================================================================
// Module : periph_bus_arbiter
// Brief  : Round-robin owner of the shared peripheral command bus with locked
//          bursts. Optional macro PERIPH_ARB_LOCK_LIMIT_EN caps bursts at
//          LOCK_MAX consecutive issues.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module periph_bus_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int DATA_W   = periph_bus_pkg::DATA_W,
  parameter int DEV_W    = periph_bus_pkg::DEV_W,
  parameter int CMD_W    = periph_bus_pkg::CMD_W,
  parameter int LOCK_MAX = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ*DEV_W-1:0]    req_device,
  input  logic [NUM_REQ*CMD_W-1:0]    req_command,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DEV_W-1:0]            bus_device,
  output logic [CMD_W-1:0]            bus_command,
  output logic [DATA_W-1:0]           bus_data,
  output logic                        busy
);

  import periph_bus_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e            r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant, r_ack, w_grant_nxt;
  logic [DEV_W-1:0]      r_bus_dev, w_bus_dev_nxt;
  logic [CMD_W-1:0]      r_bus_cmd, w_bus_cmd_nxt;
  logic [DATA_W-1:0]     r_bus_data, w_bus_data_nxt;
  logic [IDX_W-1:0]      r_last, w_last_nxt, w_sel, w_pick_idx;
  logic [NUM_REQ-1:0]    w_pick;
  logic                  w_pick_any, w_issue, w_limit;

  logic [DEV_W-1:0]      w_dev  [NUM_REQ];
  logic [CMD_W-1:0]      w_cmd  [NUM_REQ];
  logic [DATA_W-1:0]     w_data [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_dev[gi]  = req_device[gi*DEV_W +: DEV_W];
    assign w_cmd[gi]  = req_command[gi*CMD_W +: CMD_W];
    assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req        (req),
    .i_last_owner (r_last),
    .o_winner     (w_pick),
    .o_idx        (w_pick_idx),
    .o_any        (w_pick_any)
  );

`ifdef PERIPH_ARB_LOCK_LIMIT_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] r_issue_cnt;

  assign w_limit = (r_issue_cnt >= CNT_W'(LOCK_MAX));

  // Consecutive issues by the current owner; the first issue out of IDLE counts as one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_issue_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_issue_cnt <= w_issue ? CNT_W'(1) : '0;
    end else if (w_issue && !w_limit) begin
      r_issue_cnt <= r_issue_cnt + CNT_W'(1);
    end
  end
`else
  logic w_unused_lock_max;

  assign w_unused_lock_max = (LOCK_MAX > 0);
  assign w_limit           = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = '0;
    w_last_nxt  = r_last;
    w_sel       = r_last;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_sel = w_pick_idx;
        if (w_pick_any) begin
          w_issue     = 1'b1;
          w_grant_nxt = w_pick;
          w_last_nxt  = w_pick_idx;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_LOCKED: begin
        // The owner is always r_last while the bus is held.
        if (req[r_last] && lock[r_last] && !w_limit) begin
          w_issue     = 1'b1;
          w_grant_nxt = r_grant;
          w_state_nxt = ST_LOCKED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_issue) begin
      w_bus_dev_nxt  = w_dev[w_sel];
      w_bus_cmd_nxt  = w_cmd[w_sel];
      w_bus_data_nxt = w_data[w_sel];
    end else begin
      w_bus_dev_nxt  = '1;
      w_bus_cmd_nxt  = CMD_W'(CMD_NOP);
      w_bus_data_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_ack      <= '0;
      r_bus_dev  <= '1;
      r_bus_cmd  <= CMD_W'(CMD_NOP);
      r_bus_data <= '0;
      r_last     <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_ack      <= w_grant_nxt;
      r_bus_dev  <= w_bus_dev_nxt;
      r_bus_cmd  <= w_bus_cmd_nxt;
      r_bus_data <= w_bus_data_nxt;
      r_last     <= w_last_nxt;
    end
  end

  assign grant       = r_grant;
  assign ack         = r_ack;
  assign bus_device  = r_bus_dev;
  assign bus_command = r_bus_cmd;
  assign bus_data    = r_bus_data;
  assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_periph_bus_arbiter.sv
// ============================================================================
// Module : tb_periph_bus_arbiter
// Brief  : Self-checking bench for periph_bus_arbiter with queued requesters
//          and a transaction-level arbitration reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_periph_bus_arbiter;

  localparam int NUM_REQ  = 3;
  localparam int DATA_W   = 32;
  localparam int DEV_W    = 5;
  localparam int CMD_W    = 6;
  localparam int LOCK_MAX = 4;
  localparam int OBS_W    = 2*NUM_REQ + DEV_W + CMD_W + DATA_W + 1;

  localparam logic [4:0] DEV_LED   = periph_bus_pkg::DEV_LED;
  localparam logic [5:0] CMD_NOP   = periph_bus_pkg::CMD_NOP;
  localparam logic [5:0] CMD_WRITE = periph_bus_pkg::CMD_WRITE;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req, lock;
  logic [NUM_REQ*DEV_W-1:0]  req_device;
  logic [NUM_REQ*CMD_W-1:0]  req_command;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant, ack;
  logic [DEV_W-1:0]          bus_device;
  logic [CMD_W-1:0]          bus_command;
  logic [DATA_W-1:0]         bus_data;
  logic                      busy;

  always #5 clk = ~clk;

  periph_bus_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .DEV_W    (DEV_W),
    .CMD_W    (CMD_W),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .req_device  (req_device),
    .req_command (req_command),
    .req_data    (req_data),
    .grant       (grant),
    .ack         (ack),
    .bus_device  (bus_device),
    .bus_command (bus_command),
    .bus_data    (bus_data),
    .busy        (busy)
  );

  typedef struct {
    logic [4:0]  dev;
    logic [5:0]  cmd;
    logic [31:0] data;
    logic        lk;
  } item_t;

  item_t              q [NUM_REQ][$];
  logic [NUM_REQ-1:0] en;
  bit                 rnd_en;
  int                 n_tests, n_fail;

  // Reference model: current owner (-1 = bus idle), rotation pointer, burst length.
  int                 m_owner, m_last, m_cnt;
  logic [OBS_W-1:0]   expv, obs;
  logic [31:0]        led_reg;

  assign obs = {grant, ack, bus_device, bus_command, bus_data, busy};

  // LED register slave decoding the bus.
  always @(posedge clk) begin
    if (reset) led_reg <= 32'h0;
    else if (bus_device == DEV_LED && bus_command == CMD_WRITE) led_reg <= bus_data;
  end

  function automatic item_t mk(logic [4:0] d, logic [5:0] c, logic [31:0] x, logic l);
    item_t it;
    it.dev = d; it.cmd = c; it.data = x; it.lk = l;
    return it;
  endfunction

  function automatic void drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (q[i].size() > 0) begin
        req[i] = en[i];
        lock[i] = q[i][0].lk;
        req_device[i*DEV_W +: DEV_W] = q[i][0].dev;
        req_command[i*CMD_W +: CMD_W] = q[i][0].cmd;
        req_data[i*DATA_W +: DATA_W] = q[i][0].data;
      end else begin
        req[i] = 1'b0;
        lock[i] = 1'b0;
        req_device[i*DEV_W +: DEV_W] = '0;
        req_command[i*CMD_W +: CMD_W] = '0;
        req_data[i*DATA_W +: DATA_W] = '0;
      end
    end
  endfunction

  function automatic bit under_cap();
`ifdef PERIPH_ARB_LOCK_LIMIT_EN
    return m_cnt < LOCK_MAX;
`else
    return 1'b1;
`endif
  endfunction

  // Predict the outputs that appear after the coming edge from the inputs it samples.
  function automatic void predict();
    logic [NUM_REQ-1:0] g;
    logic [DEV_W-1:0]   d;
    logic [CMD_W-1:0]   c;
    logic [DATA_W-1:0]  x;
    g = '0; d = '1; c = '0; x = '0;
    if (reset) begin
      m_owner = -1; m_last = NUM_REQ - 1; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int cand;
        cand = (m_last + k) % NUM_REQ;
        if (m_owner < 0 && req[cand]) begin
          m_owner = cand; m_last = cand; m_cnt = 1;
        end
      end
    end else if (req[m_owner] && lock[m_owner] && under_cap()) begin
      m_cnt++;
    end else begin
      m_owner = -1;
    end
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      d = req_device[m_owner*DEV_W +: DEV_W];
      c = req_command[m_owner*CMD_W +: CMD_W];
      x = req_data[m_owner*DATA_W +: DATA_W];
    end
    expv = {g, g, d, c, x, (m_owner >= 0)};
  endfunction

  task automatic cycle();
    predict();
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (expv[OBS_W-1-(NUM_REQ-1-i)]) q[i].delete(0);
    if (rnd_en) for (int i = 0; i < NUM_REQ; i++) en[i] = ($urandom_range(0, 4) != 0);
    else en = '1;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rnd_en = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    en = '1;
    drive();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rnd_en = 1'b0; en = '1;
    drive();
    cycle();
    cycle();
    n_tests++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b, expected 000", grant); end
    n_tests++; if (ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b, expected 000", ack); end
    n_tests++; if (bus_device !== 5'h1F) begin n_fail++; $display("FAIL reset_dev: got %h, expected 1f", bus_device); end
    n_tests++; if (bus_command !== 6'h00) begin n_fail++; $display("FAIL reset_cmd: got %h, expected 00", bus_command); end
    n_tests++; if (bus_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", bus_data); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    q[0].push_back(mk(DEV_LED, CMD_WRITE, 32'h0000_00A5, 1'b0));
    drive();
    cycle();
    n_tests++;
    if ({grant, ack, bus_device, bus_command, bus_data} !== {3'b001, 3'b001, 5'd0, 6'd1, 32'hA5}) begin
      n_fail++;
      $display("FAIL single_issue: got g=%b a=%b bus=%h/%h/%h, expected 001/001 00/01/000000a5", grant, ack, bus_device, bus_command, bus_data);
    end
    cycle();
    n_tests++;
    if ({ack, bus_device, bus_command} !== {3'b000, 5'h1F, 6'd0}) begin
      n_fail++;
      $display("FAIL single_release: got a=%b bus=%h/%h, expected 000 1f/00", ack, bus_device, bus_command);
    end
    n_tests++; if (led_reg !== 32'hA5) begin n_fail++; $display("FAIL single_led: got %h, expected a5", led_reg); end
  endtask

  task automatic test_round_robin();
    logic [2:0] tr [8];
    logic [2:0] want [8] = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd1, 3'd0, 3'd2, 3'd0};
    do_reset();
    for (int k = 0; k < 2; k++) begin
      q[0].push_back(mk(5'd3, CMD_WRITE, 32'h100 + k, 1'b0));
      q[1].push_back(mk(5'd4, CMD_WRITE, 32'h200 + k, 1'b0));
    end
    drive();
    for (int c = 0; c < 8; c++) begin
      cycle();
      tr[c] = grant;
      n_tests++; if (obs !== expv) begin n_fail++; $display("FAIL rr_model c=%0d: got %h, expected %h", c, obs, expv); end
    end
    for (int c = 0; c < 8; c++) begin
      n_tests++; if (tr[c] !== want[c]) begin n_fail++; $display("FAIL rr_order c=%0d: got %b, expected %b", c, tr[c], want[c]); end
    end
  endtask

  task automatic test_locked_burst();
    logic [2:0]  tr [6];
    logic [2:0]  want [6] = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd1, 3'd0};
    logic [31:0] dw [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    int          nd;
    do_reset();
    nd = 0;
    for (int k = 0; k < 3; k++) q[1].push_back(mk(5'd7, CMD_WRITE, dw[k], 1'b1));
    drive();
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (c == 0) begin q[0].push_back(mk(5'd2, CMD_WRITE, 32'hCAFE, 1'b0)); drive(); end
      tr[c] = grant;
      n_tests++; if (obs !== expv) begin n_fail++; $display("FAIL lock_model c=%0d: got %h, expected %h", c, obs, expv); end
      if (ack[1] && nd < 3) begin
        n_tests++; if (bus_data !== dw[nd]) begin n_fail++; $display("FAIL lock_data %0d: got %h, expected %h", nd, bus_data, dw[nd]); end
        nd++;
      end
    end
    for (int c = 0; c < 6; c++) begin
      n_tests++; if (tr[c] !== want[c]) begin n_fail++; $display("FAIL lock_order c=%0d: got %b, expected %b", c, tr[c], want[c]); end
    end
  endtask

`ifdef PERIPH_ARB_LOCK_LIMIT_EN
  task automatic test_lock_limit();
    logic [2:0] tr [8];
    logic [2:0] want [8] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd2, 3'd0, 3'd1};
    int         c;
    do_reset();
    for (int k = 0; k < 10; k++) q[0].push_back(mk(5'd5, CMD_WRITE, 32'hA000 + k, 1'b1));
    q[1].push_back(mk(5'd6, CMD_WRITE, 32'hB000, 1'b0));
    drive();
    c = 0;
    while ((q[0].size() > 0 || q[1].size() > 0) && c < 60) begin
      cycle();
      if (c < 8) tr[c] = grant;
      n_tests++; if (obs !== expv) begin n_fail++; $display("FAIL limit_model c=%0d: got %h, expected %h", c, obs, expv); end
      c++;
    end
    for (int k = 0; k < 8; k++) begin
      n_tests++; if (tr[k] !== want[k]) begin n_fail++; $display("FAIL limit_order c=%0d: got %b, expected %b", k, tr[k], want[k]); end
    end
    n_tests++; if (c >= 60) begin n_fail++; $display("FAIL limit_timeout: got %0d cycles, expected drain under 60", c); end
  endtask
`endif

  task automatic test_reset_mid_burst();
    do_reset();
    for (int k = 0; k < 6; k++) q[0].push_back(mk(5'd9, CMD_WRITE, 32'hD000 + k, 1'b1));
    drive();
    for (int c = 0; c < 2; c++) begin
      cycle();
      n_tests++; if (obs !== expv) begin n_fail++; $display("FAIL rstb_model c=%0d: got %h, expected %h", c, obs, expv); end
    end
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    drive();
    cycle();
    n_tests++;
    if ({grant, ack, bus_device, bus_command, busy} !== {3'b000, 3'b000, 5'h1F, 6'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL rstb_abort: got g=%b a=%b bus=%h/%h busy=%b, expected 000/000 1f/00 0", grant, ack, bus_device, bus_command, busy);
    end
    reset = 1'b0;
    q[1].push_back(mk(5'd1, CMD_WRITE, 32'h11, 1'b0));
    q[0].push_back(mk(5'd1, CMD_WRITE, 32'h10, 1'b0));
    drive();
    cycle();
    n_tests++; if (grant !== 3'b001) begin n_fail++; $display("FAIL rstb_pointer: got %b, expected 001", grant); end
    for (int c = 0; c < 4; c++) cycle();
  endtask

  task automatic test_nop_command();
    int nack;
    bit cmd_seen;
    do_reset();
    q[0].push_back(mk(DEV_LED, CMD_WRITE, 32'h3C, 1'b0));
    drive();
    for (int c = 0; c < 3; c++) cycle();
    q[0].push_back(mk(DEV_LED, CMD_NOP, 32'h5A, 1'b0));
    drive();
    nack = 0; cmd_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (ack[0]) nack++;
      if (bus_command !== 6'd0) cmd_seen = 1'b1;
      n_tests++; if (obs !== expv) begin n_fail++; $display("FAIL nop_model c=%0d: got %h, expected %h", c, obs, expv); end
    end
    n_tests++; if (nack !== 1) begin n_fail++; $display("FAIL nop_ack: got %0d pulses, expected 1", nack); end
    n_tests++; if (cmd_seen !== 1'b0) begin n_fail++; $display("FAIL nop_cmd: got non-NOP command, expected 00"); end
    n_tests++; if (led_reg !== 32'h3C) begin n_fail++; $display("FAIL nop_led: got %h, expected 3c", led_reg); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int c;
      do_reset();
      rnd_en = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        int n;
        n = $urandom_range(1, 8);
        for (int k = 0; k < n; k++)
          q[i].push_back(mk(5'($urandom_range(0, 31)), 6'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1))));
      end
      drive();
      c = 0;
      while ((q[0].size() + q[1].size() + q[2].size() > 0 || m_owner >= 0) && c < 500) begin
        cycle();
        n_tests++; if (obs !== expv) begin n_fail++; $display("FAIL rand_model r=%0d c=%0d: got %h, expected %h", r, c, obs, expv); end
        c++;
      end
      n_tests++; if (c >= 500) begin n_fail++; $display("FAIL rand_timeout r=%0d: got %0d cycles, expected drain under 500", r, c); end
      rnd_en = 1'b0;
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; rnd_en = 1'b0;
    m_owner = -1; m_last = NUM_REQ - 1; m_cnt = 0;
    reset = 1'b1; en = '1;
    drive();
    test_reset();
    test_single_write();
    test_round_robin();
    test_locked_burst();
`ifdef PERIPH_ARB_LOCK_LIMIT_EN
    test_lock_limit();
`endif
    test_reset_mid_burst();
    test_nop_command();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
